// File: rtl/line_matrix_cfg_master_if.sv
// Command and matrix pin bundle for line_matrix_cfg_master.
// master: the driver block; slave: command source / matrix side.
interface line_matrix_cfg_master_if #(
    parameter int IN_SEL_W  = 4,
    parameter int OUT_SEL_W = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [IN_SEL_W-1:0]  cmd_in_sel;
    logic [OUT_SEL_W-1:0] cmd_out_sel;
    logic                 mtx_clk;
    logic                 mtx_rstn;
    logic [IN_SEL_W-1:0]  mtx_in_sel;
    logic [OUT_SEL_W-1:0] mtx_out_sel;
    logic                 done;
    logic                 err;
    logic                 busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_in_sel, cmd_out_sel,
        output cmd_ready, mtx_clk, mtx_rstn, mtx_in_sel, mtx_out_sel,
        output done, err, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_in_sel, cmd_out_sel,
        input  cmd_ready, mtx_clk, mtx_rstn, mtx_in_sel, mtx_out_sel,
        input  done, err, busy
    );
endinterface

// File: rtl/line_matrix_cfg_master.sv
// Line matrix configuration driver: timed clock/reset/select sequencing.
// Define LMC_SHADOW_EN to add a readable shadow table of written routes.
module line_matrix_cfg_master #(
    parameter int IN_SEL_W    = 4,
    parameter int OUT_SEL_W   = 4,
    parameter int NUM_OUTPUTS = 9,
    parameter int CLK_DIV     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef LMC_SHADOW_EN
    input  logic [OUT_SEL_W-1:0]  rd_addr,
    output logic [IN_SEL_W:0]     rd_data,
`endif
    line_matrix_cfg_master_if.master bus
);
    localparam logic [7:0]         DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [OUT_SEL_W:0] NUM_O  = (OUT_SEL_W + 1)'(NUM_OUTPUTS);

    typedef enum logic [2:0] {
        S_INIT, S_REL, S_IDLE, S_SETUP, S_HIGH, S_HOLD, S_RST, S_DONE
    } state_t;

    state_t               state, state_n;
    logic [7:0]           cnt, cnt_n;
    logic                 half, half_n;
    logic                 err_q, err_n;
    logic [IN_SEL_W-1:0]  in_q, in_n;
    logic [OUT_SEL_W-1:0] out_q, out_n;
    logic                 clk_q, rstn_q;
    logic                 hs, illegal;

    assign hs      = bus.cmd_valid && (state == S_IDLE);
    assign illegal = {1'b0, bus.cmd_out_sel} >= NUM_O;

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.err         = (state == S_DONE) && err_q;
    assign bus.mtx_clk     = clk_q;
    assign bus.mtx_rstn    = rstn_q;
    assign bus.mtx_in_sel  = in_q;
    assign bus.mtx_out_sel = out_q;

    // Next-state, phase counter and captured command decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half;
        err_n   = err_q;
        in_n    = in_q;
        out_n   = out_q;
        unique case (state)
            S_INIT: begin
                if (cnt == 8'd0) begin
                    cnt_n = DIV_M1;
                    if (half) state_n = S_REL;
                    else      half_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_REL: state_n = S_IDLE;
            S_IDLE: begin
                if (hs) begin
                    cnt_n  = DIV_M1;
                    half_n = 1'b0;
                    err_n  = 1'b0;
                    if (bus.cmd_op) begin
                        state_n = S_RST;
                        in_n    = '0;
                        out_n   = '0;
                    end else if (illegal) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = S_SETUP;
                        in_n    = bus.cmd_in_sel;
                        out_n   = bus.cmd_out_sel;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == 8'd0) begin
                    state_n = S_HIGH;
                    cnt_n   = DIV_M1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt == 8'd0) begin
                    state_n = S_HOLD;
                    cnt_n   = DIV_M1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 8'd0) state_n = S_DONE;
                else             cnt_n   = cnt - 8'd1;
            end
            S_RST: begin
                if (cnt == 8'd0) begin
                    cnt_n = DIV_M1;
                    if (half) state_n = S_DONE;
                    else      half_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    // State registers; matrix pins registered from next state to stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_INIT;
            cnt    <= DIV_M1;
            half   <= 1'b0;
            err_q  <= 1'b0;
            in_q   <= '0;
            out_q  <= '0;
            clk_q  <= 1'b0;
            rstn_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            half   <= half_n;
            err_q  <= err_n;
            in_q   <= in_n;
            out_q  <= out_n;
            clk_q  <= (state_n == S_HIGH);
            rstn_q <= !((state_n == S_INIT) || (state_n == S_RST));
        end
    end

`ifdef LMC_SHADOW_EN
    logic [IN_SEL_W:0] shadow [NUM_OUTPUTS];
    logic [IN_SEL_W:0] rd_n;
    logic              route_done;

    // half is only left set by a matrix reset, so this marks a legal route write.
    assign route_done = (state == S_DONE) && !err_q && !half;

    // Shadow table: cleared by reset and matrix reset, written on route completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) shadow[i] <= '0;
        end else if (state == S_RST) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) shadow[i] <= '0;
        end else if (route_done) begin
            for (int i = 0; i < NUM_OUTPUTS; i++)
                if (out_q == OUT_SEL_W'(i)) shadow[i] <= {1'b1, in_q};
        end
    end

    // Read mux; out-of-range addresses fall through to zero.
    always_comb begin
        rd_n = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++)
            if (rd_addr == OUT_SEL_W'(i)) rd_n = shadow[i];
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_n;
    end
`endif
endmodule

// File: tb/tb_line_matrix_cfg_master.sv
// Directed bench for line_matrix_cfg_master (CLK_DIV=4, NUM_OUTPUTS=9).
// Checks init, route write, illegal write, matrix reset, back-to-back, abort.
module tb_line_matrix_cfg_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    line_matrix_cfg_master_if #(.IN_SEL_W(4), .OUT_SEL_W(4)) bus ();

`ifdef LMC_SHADOW_EN
    logic [3:0] rd_addr = '0;
    logic [4:0] rd_data;
`endif

    line_matrix_cfg_master #(
        .IN_SEL_W(4), .OUT_SEL_W(4), .NUM_OUTPUTS(9), .CLK_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef LMC_SHADOW_EN
        .rd_addr(rd_addr),
        .rd_data(rd_data),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(output int n, output int seen);
        n = 0;
        seen = 0;
        while (!bus.mtx_rstn && n < 50) begin
            if (bus.done) seen = 1;
            n++;
            step();
        end
    endtask

    initial begin
        int n, seen, hs, sec;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 1'b0;
        bus.cmd_in_sel  = '0;
        bus.cmd_out_sel = '0;
        repeat (3) step();
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_rstn", bus.mtx_rstn, 0);
        chk("rst_clk", bus.mtx_clk, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_in", bus.mtx_in_sel, 0);
        chk("rst_out", bus.mtx_out_sel, 0);
        rst = 1'b0;

        wait_init(n, seen);
        chk("init_len", n, 8);
        chk("init_rel_ready", bus.cmd_ready, 0);
        step();
        chk("init_ready", bus.cmd_ready, 1);
        chk("init_busy", bus.busy, 0);
        chk("init_clk", bus.mtx_clk, 0);

        // legal route write 5 -> 2
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 1'b0;
        bus.cmd_in_sel = 4'd5;
        bus.cmd_out_sel = 4'd2;
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_in", bus.mtx_in_sel, 5);
        chk("wr_out", bus.mtx_out_sel, 2);
        chk("wr_busy", bus.busy, 1);
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("wr_clk_c%0d", c), bus.mtx_clk, (c >= 5 && c <= 8));
            chk($sformatf("wr_done_c%0d", c), bus.done, (c == 13));
            chk($sformatf("wr_ready_c%0d", c), bus.cmd_ready, (c == 14));
            chk($sformatf("wr_err_c%0d", c), bus.err, 0);
            if (c < 14) step();
        end

        // illegal out_sel
        bus.cmd_valid = 1'b1;
        bus.cmd_in_sel = 4'd3;
        bus.cmd_out_sel = 4'd9;
        step();
        bus.cmd_valid = 1'b0;
        chk("ill_done", bus.done, 1);
        chk("ill_err", bus.err, 1);
        chk("ill_in", bus.mtx_in_sel, 5);
        chk("ill_out", bus.mtx_out_sel, 2);
        chk("ill_clk", bus.mtx_clk, 0);
        chk("ill_rstn", bus.mtx_rstn, 1);
        chk("ill_ready1", bus.cmd_ready, 0);
        step();
        chk("ill_ready2", bus.cmd_ready, 1);
        chk("ill_done2", bus.done, 0);
        chk("ill_err2", bus.err, 0);

        // matrix reset
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("mr_rstn_c%0d", c), bus.mtx_rstn, (c >= 9));
            chk($sformatf("mr_done_c%0d", c), bus.done, (c == 9));
            chk($sformatf("mr_ready_c%0d", c), bus.cmd_ready, (c == 10));
            if (c <= 8) begin
                chk($sformatf("mr_in_c%0d", c), bus.mtx_in_sel, 0);
                chk($sformatf("mr_out_c%0d", c), bus.mtx_out_sel, 0);
            end
            if (c < 10) step();
        end

        // back-to-back with cmd_valid held high
        bus.cmd_valid = 1'b1;
        bus.cmd_in_sel = 4'd7;
        bus.cmd_out_sel = 4'd4;
        hs = 0;
        sec = -1;
        for (int c = 0; c <= 40; c++) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs++;
                if (hs == 2) sec = c;
            end
            step();
            if (c == 0) begin
                bus.cmd_in_sel = 4'd1;
                bus.cmd_out_sel = 4'd3;
            end
            if (hs == 2) break;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_second_cycle", sec, 14);
        chk("b2b_hs_count", hs, 2);
        chk("b2b_in", bus.mtx_in_sel, 1);
        chk("b2b_out", bus.mtx_out_sel, 3);
        n = 0;
        while (!bus.done && n < 40) begin
            n++;
            step();
        end
        chk("b2b_done_seen", bus.done, 1);
        chk("b2b_done_lat", n, 12);
        step();
        chk("b2b_ready", bus.cmd_ready, 1);

`ifdef LMC_SHADOW_EN
        rd_addr = 4'd4;
        step();
        chk("sh_rd4", rd_data, 5'h17);
        rd_addr = 4'd3;
        step();
        chk("sh_rd3", rd_data, 5'h11);
        rd_addr = 4'd2;
        step();
        chk("sh_rd2_cleared", rd_data, 0);
        rd_addr = 4'd9;
        step();
        chk("sh_rd9", rd_data, 0);
`endif

        // abort in the middle of a route write
        bus.cmd_valid = 1'b1;
        bus.cmd_in_sel = 4'd6;
        bus.cmd_out_sel = 4'd5;
        step();
        bus.cmd_valid = 1'b0;
        repeat (5) step();
        chk("ab_clk_high", bus.mtx_clk, 1);
        rst = 1'b1;
        #1;
        chk("ab_clk", bus.mtx_clk, 0);
        chk("ab_rstn", bus.mtx_rstn, 0);
        chk("ab_done", bus.done, 0);
        chk("ab_ready", bus.cmd_ready, 0);
        chk("ab_busy", bus.busy, 1);
        chk("ab_in", bus.mtx_in_sel, 0);
        step();
        rst = 1'b0;
        wait_init(n, seen);
        chk("ab_init_len", n, 8);
        chk("ab_no_done", seen, 0);
        step();
        chk("ab_ready2", bus.cmd_ready, 1);

`ifdef LMC_SHADOW_EN
        rd_addr = 4'd4;
        step();
        chk("ab_sh_rd4", rd_data, 0);
        rd_addr = 4'd3;
        step();
        chk("ab_sh_rd3", rd_data, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
